// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ack handshake with WAIT_CYCLES wait states.
// Request fields are latched in IDLE; later changes on the inputs are ignored until the access completes.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        ack,
  output logic [31:0] read_data,
  output logic        err,
  output logic        busy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [29:0] IDX_LIM = 30'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  state_t      w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_latch;
  logic        w_enter_resp;
  logic        w_acc_write;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [29:0] w_idx;
  logic [AW-1:0] w_mem_idx;
  logic        w_bad;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_latch      = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_latch   = 1'b1;
          w_cnt_nxt = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            w_state_nxt  = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
        // RESP is entered on the edge that takes the counter to zero
        if (r_cnt <= 4'd1) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the sampling edge, so use the live inputs then
  always_comb begin
    w_acc_write = w_latch ? write      : r_write;
    w_acc_addr  = w_latch ? address    : r_addr;
    w_acc_wdata = w_latch ? write_data : r_wdata;
    w_idx       = w_acc_addr[31:2];
    w_mem_idx   = w_idx[AW-1:0];
    w_bad       = (w_acc_addr[1:0] != 2'b00) || (w_idx >= IDX_LIM);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_enter_resp;
      r_err   <= w_enter_resp & w_bad;
      if (w_latch) begin
        r_write <= write;
        r_addr  <= address;
        r_wdata <= write_data;
      end
      if (w_enter_resp) begin
        if (w_bad)             r_rdata <= 32'd0;
        else if (!w_acc_write) r_rdata <= r_mem[w_mem_idx];
      end
    end
  end

  // Storage has no reset; a reset on the RESP-entry edge suppresses the write
  always_ff @(posedge clk) begin
    if (nrst && w_enter_resp && w_acc_write && !w_bad)
      r_mem[w_mem_idx] <= w_acc_wdata;
  end

  assign ack       = r_ack;
  assign err       = r_err;
  assign read_data = r_rdata;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 2 wait states, one with none.
// Expected responses are predicted from a memory model and queued at drive time.
module tb_mem_responder;

  logic        clk;
  logic        nrst;
  logic        req,  wr,  req0,  wr0;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic        ack,  err,  busy,  ack0,  err0,  busy0;
  logic [31:0] rdata, rdata0;

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .nrst(nrst), .req(req), .write(wr), .address(addr), .write_data(wdata),
    .ack(ack), .read_data(rdata), .err(err), .busy(busy)
  );

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .nrst(nrst), .req(req0), .write(wr0), .address(addr0), .write_data(wdata0),
    .ack(ack0), .read_data(rdata0), .err(err0), .busy(busy0)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m0 [int];
  logic [31:0] m1 [int];
  logic [31:0] last0, last1;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          t_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic o_ack(input bit sel);  return sel ? ack0  : ack;   endfunction
  function automatic logic o_err(input bit sel);  return sel ? err0  : err;   endfunction
  function automatic logic o_busy(input bit sel); return sel ? busy0 : busy;  endfunction
  function automatic logic [31:0] o_rd(input bit sel); return sel ? rdata0 : rdata; endfunction

  // Reference behaviour: misaligned or out-of-range -> err with zero data
  task automatic predict(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   idx;
    idx   = int'(a[31:2]);
    e.lat = sel ? 1 : 3;
    if (a[1:0] != 2'b00 || a[31:2] >= 30'd256) begin
      e.err = 1'b1; e.rdata = 32'd0;
      if (sel) last1 = 32'd0; else last0 = 32'd0;
    end else if (w) begin
      e.err = 1'b0; e.rdata = sel ? last1 : last0;
      if (sel) m1[idx] = d; else m0[idx] = d;
    end else begin
      e.err   = 1'b0;
      e.rdata = sel ? m1[idx] : m0[idx];
      if (sel) last1 = e.rdata; else last0 = e.rdata;
    end
    sb.push_back(e);
  endtask

  task automatic start(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    if (sel) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
    else     begin req  = 1'b1; wr  = w; addr  = a; wdata  = d; end
    predict(sel, w, a, d);
  endtask

  // Counts edges from the sampling edge until ack; scramble alters inputs while busy
  task automatic run(input bit sel, input bit scramble);
    int   n;
    bit   got;
    exp_t e;
    n = 0; got = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1; n++;
      if (scramble && n == 1) begin wr = 1'b0; addr = 32'h40; wdata = 32'h0BADBAD0; end
      if (o_ack(sel)) begin got = 1; break; end
      chk("busy_wait", {31'd0, o_busy(sel)}, 32'd1);
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("latency", n, e.lat);
      chk("err", {31'd0, o_err(sel)}, {31'd0, e.err});
      chk("read_data", o_rd(sel), e.rdata);
    end
    chk("busy_resp", {31'd0, o_busy(sel)}, 32'd1);
    ack_cyc = cyc;
    if (sel) req0 = 1'b0; else req = 1'b0;
    @(posedge clk); #1;
    chk("ack_pulse", {31'd0, o_ack(sel)}, 32'd0);
    chk("busy_exit", {31'd0, o_busy(sel)}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0;
    req = 0; wr = 0; addr = 0; wdata = 0; req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    last0 = 0; last1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); nrst = 1'b1;

    // Store then load, back to back: ack spacing is WAIT_CYCLES+2
    start(0, 1, 32'h10, 32'hDEADBEEF); run(0, 0);
    t_prev = ack_cyc;
    start(0, 0, 32'h10, 32'h0);        run(0, 0);
    chk("b2b_w2", ack_cyc - t_prev, 32'd4);

    start(0, 0, 32'h13, 32'h0);        run(0, 0);
    start(0, 0, 32'h10, 32'h0);        run(0, 0);

    // Index 256 is one past the end
    start(0, 1, 32'h3FC, 32'hA1A1A1A1); run(0, 0);
    start(0, 1, 32'h400, 32'h12345678); run(0, 0);
    start(0, 0, 32'h3FC, 32'h0);        run(0, 0);

    // Inputs scrambled after sampling must not affect the store to 0x30
    start(0, 1, 32'h40, 32'h44444444); run(0, 0);
    start(0, 1, 32'h30, 32'hA5A5A5A5); run(0, 1);
    start(0, 0, 32'h30, 32'h0);        run(0, 0);
    start(0, 0, 32'h40, 32'h0);        run(0, 0);

    // Reset one cycle into a store aborts it; req held during reset waits for release
    start(0, 1, 32'h20, 32'h11111111); run(0, 0);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("abort_busy_on", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ack", {31'd0, ack}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    last0 = 32'd0; last1 = 32'd0;
    req = 1'b0;
    start(0, 0, 32'h20, 32'h0);
    @(posedge clk); #1;
    chk("rst_req_ignored", {31'd0, ack | busy}, 32'd0);
    @(negedge clk); nrst = 1'b1;
    run(0, 0);

    // Zero wait states: ack on the sampling edge, every 2 cycles back to back
    start(1, 1, 32'h8, 32'h00000077); run(1, 0);
    t_prev = ack_cyc;
    start(1, 0, 32'h8, 32'h0);        run(1, 0);
    chk("b2b_w0", ack_cyc - t_prev, 32'd2);
    t_prev = ack_cyc;
    start(1, 0, 32'h9, 32'h0);        run(1, 0);
    chk("b2b_w0_err", ack_cyc - t_prev, 32'd2);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
